// File: rtl/fir_coeff_bank_ctrl.sv
// Coefficient shadow/active bank controller for a 4-band FIR filter bank.
// Host writes go to shadow storage; a commit copies one band to active storage on a sample tick.
module fir_coeff_bank_ctrl #(
  parameter int ORDER  = 30,
  parameter int NBANDS = 4,
  parameter int CW     = 16
) (
  input  logic                       clk_slow,
  input  logic                       rst,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [1:0]                 wr_band,
  input  logic [4:0]                 wr_idx,
  input  logic [CW-1:0]              wr_data,
  input  logic                       commit_req,
  input  logic [1:0]                 commit_band,
  output logic                       commit_ack,
  input  logic                       sample_tick,
  output logic [NBANDS*ORDER*CW-1:0] coef_active,
  output logic [NBANDS-1:0]          band_valid,
  output logic                       busy,
  output logic                       err_idx
);

  localparam logic [4:0] ORDER_IDX = 5'(ORDER);
  localparam int         SET_W     = ORDER * CW;

  typedef enum logic [1:0] {IDLE, WAIT_TICK, COPY} state_t;

  state_t                       state;
  logic [1:0]                   band_q;
  logic [NBANDS*ORDER*CW-1:0]   shadow;
  logic [CW-1:0]                wdata_norm;

  // Negative zero collapses to +0 so downstream filters see a single zero encoding.
  assign wdata_norm = (wr_data[CW-2:0] == '0) ? '0 : wr_data;
  assign wr_ready   = (state == IDLE);

  always_ff @(posedge clk_slow or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      band_q      <= '0;
      shadow      <= '0;
      coef_active <= '0;
      band_valid  <= '0;
      commit_ack  <= 1'b0;
      busy        <= 1'b0;
      err_idx     <= 1'b0;
    end else begin
      commit_ack <= 1'b0;

      // A write accepted alongside commit_req lands here first, so the commit includes it.
      if (state == IDLE && wr_valid) begin
        if (wr_idx >= ORDER_IDX)
          err_idx <= 1'b1;
        else
          shadow[(int'(wr_band) * ORDER + int'(wr_idx)) * CW +: CW] <= wdata_norm;
      end

      case (state)
        IDLE: begin
          if (commit_req) begin
            band_q <= commit_band;
            busy   <= 1'b1;
            state  <= WAIT_TICK;
          end
        end
        WAIT_TICK: begin
          if (sample_tick)
            state <= COPY;
        end
        COPY: begin
          for (int unsigned b = 0; b < NBANDS; b++) begin
            if (band_q == 2'(b)) begin
              coef_active[b*SET_W +: SET_W] <= shadow[b*SET_W +: SET_W];
              band_valid[b]                 <= 1'b1;
            end
          end
          commit_ack <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_coeff_bank_ctrl.sv
// Scoreboard bench for fir_coeff_bank_ctrl: the driver predicts each commit from a shadow/active
// array model, and a monitor checks every commit_ack against the queued prediction.
module tb_fir_coeff_bank_ctrl;
  localparam int ORDER = 30;
  localparam int NB    = 4;
  localparam int CW    = 16;
  localparam int W     = NB * ORDER * CW;

  logic          clk_slow = 1'b0;
  logic          rst;
  logic          wr_valid;
  logic          wr_ready;
  logic [1:0]    wr_band;
  logic [4:0]    wr_idx;
  logic [CW-1:0] wr_data;
  logic          commit_req;
  logic [1:0]    commit_band;
  logic          commit_ack;
  logic          sample_tick;
  logic [W-1:0]  coef_active;
  logic [NB-1:0] band_valid;
  logic          busy;
  logic          err_idx;

  fir_coeff_bank_ctrl #(.ORDER(ORDER), .NBANDS(NB), .CW(CW)) dut (
    .clk_slow   (clk_slow),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_band    (wr_band),
    .wr_idx     (wr_idx),
    .wr_data    (wr_data),
    .commit_req (commit_req),
    .commit_band(commit_band),
    .commit_ack (commit_ack),
    .sample_tick(sample_tick),
    .coef_active(coef_active),
    .band_valid (band_valid),
    .busy       (busy),
    .err_idx    (err_idx)
  );

  always #5 clk_slow = ~clk_slow;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk_slow) cyc <= cyc + 1;

  // Reference model: plain arrays of shadow and active words.
  logic [CW-1:0] sh  [NB][ORDER];
  logic [CW-1:0] act [NB][ORDER];
  logic [NB-1:0] bv_m;
  logic          err_m;
  int            pending_band;

  typedef struct {
    int            ack_cyc;
    logic [W-1:0]  coefs;
    logic [NB-1:0] bv;
  } exp_t;
  exp_t q[$];

  function automatic logic [W-1:0] flat_active();
    logic [W-1:0] v;
    for (int b = 0; b < NB; b++)
      for (int i = 0; i < ORDER; i++)
        v[(b*ORDER+i)*CW +: CW] = act[b][i];
    return v;
  endfunction

  function automatic void model_reset();
    for (int b = 0; b < NB; b++)
      for (int i = 0; i < ORDER; i++) begin
        sh[b][i]  = '0;
        act[b][i] = '0;
      end
    bv_m         = '0;
    err_m        = 1'b0;
    pending_band = -1;
  endfunction

  function automatic void model_write(int b, int idx, logic [CW-1:0] d);
    if (idx >= ORDER) err_m = 1'b1;
    else if (d[CW-2:0] == 0) sh[b][idx] = '0;
    else sh[b][idx] = d;
  endfunction

  task automatic chk(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic chk_vec(string name, logic [W-1:0] a, logic [W-1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      for (int k = 0; k < NB*ORDER; k++) begin
        if (a[k*CW +: CW] !== e[k*CW +: CW]) begin
          $display("FAIL %s: band %0d tap %0d got %0h expected %0h (cycle %0d)",
                   name, k / ORDER, k % ORDER, a[k*CW +: CW], e[k*CW +: CW], cyc);
          break;
        end
      end
    end
  endtask

  // Monitor: every ack must match the oldest predicted commit.
  always @(negedge clk_slow) begin
    exp_t e;
    if (rst === 1'b1 && commit_ack === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got ack expected none (cycle %0d)", cyc);
      end else begin
        e = q.pop_front();
        chk("ack_latency", cyc, e.ack_cyc);
        chk_vec("ack_coefs", coef_active, e.coefs);
        chk("ack_band_valid", 32'(band_valid), 32'(e.bv));
      end
    end
  end

  task automatic idle(int n);
    repeat (n) @(posedge clk_slow);
    #1;
  endtask

  task automatic do_write(int b, int idx, logic [CW-1:0] d);
    chk("wr_ready_idle", 32'(wr_ready), 32'd1);
    wr_valid = 1'b1;
    wr_band  = 2'(b);
    wr_idx   = 5'(idx);
    wr_data  = d;
    model_write(b, idx, d);
    idle(1);
    wr_valid = 1'b0;
  endtask

  task automatic do_req(int b);
    commit_req   = 1'b1;
    commit_band  = 2'(b);
    pending_band = b;
    idle(1);
    commit_req = 1'b0;
    chk("busy_wait", 32'(busy), 32'd1);
    chk("wr_ready_wait", 32'(wr_ready), 32'd0);
  endtask

  task automatic do_tick();
    exp_t e;
    sample_tick = 1'b1;
    if (pending_band >= 0) begin
      for (int i = 0; i < ORDER; i++) act[pending_band][i] = sh[pending_band][i];
      bv_m[pending_band] = 1'b1;
      e.ack_cyc = cyc + 2;
      e.coefs   = flat_active();
      e.bv      = bv_m;
      q.push_back(e);
      pending_band = -1;
    end
    idle(1);
    sample_tick = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && q.size() != 0; i++) @(posedge clk_slow);
    #1;
    chk("ack_outstanding", q.size(), 0);
    q.delete();
    chk("busy_after_ack", 32'(busy), 32'd0);
  endtask

  task automatic do_commit(int b, int gap);
    do_req(b);
    idle(gap);
    do_tick();
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; wr_valid = 1'b0; wr_band = '0; wr_idx = '0; wr_data = '0;
    commit_req = 1'b0; commit_band = '0; sample_tick = 1'b0;
    model_reset();
    idle(3);
    rst = 1'b1;
    idle(1);

    chk_vec("reset_active", coef_active, '0);
    chk("reset_band_valid", 32'(band_valid), 32'd0);
    chk("reset_wr_ready", 32'(wr_ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_err_idx", 32'(err_idx), 32'd0);
    chk("reset_ack", 32'(commit_ack), 32'd0);

    // Basic load with a write attempt held off during the wait.
    do_write(1, 3, 16'h0080);
    do_write(1, 4, 16'h0040);
    do_req(1);
    wr_valid = 1'b1; wr_band = 2'd1; wr_idx = 5'd3; wr_data = 16'hffff;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("holdoff_wr_ready", 32'(wr_ready), 32'd0);
      chk("holdoff_busy", 32'(busy), 32'd1);
    end
    wr_valid = 1'b0;
    idle(1);
    do_tick();
    drain();
    chk("basic_tap3", 32'(coef_active[(1*ORDER+3)*CW +: CW]), 32'h0080);
    chk("basic_tap4", 32'(coef_active[(1*ORDER+4)*CW +: CW]), 32'h0040);
    chk("basic_band_valid", 32'(band_valid), 32'b0010);

    // Shadow change stays invisible until the next commit.
    do_write(1, 3, 16'h0111);
    idle(2);
    chk("shadow_isolated", 32'(coef_active[(1*ORDER+3)*CW +: CW]), 32'h0080);
    do_commit(1, 3);
    do_commit(1, 0);

    // Boundary indices and sign-magnitude zero.
    do_write(0, 29, 16'h8000);
    do_write(0, 28, 16'h8001);
    do_write(0, 30, 16'h1234);
    chk("err_idx_set", 32'(err_idx), 32'd1);
    do_commit(0, 2);
    chk("negzero_tap29", 32'(coef_active[29*CW +: CW]), 32'h0000);
    idle(3);
    chk("err_idx_sticky", 32'(err_idx), 32'd1);

    // Tick in the same cycle as the request is ignored.
    commit_req = 1'b1; commit_band = 2'd3; sample_tick = 1'b1;
    pending_band = 3;
    idle(1);
    commit_req = 1'b0; sample_tick = 1'b0;
    idle(4);
    chk("same_cycle_tick_busy", 32'(busy), 32'd1);
    do_tick();
    drain();

    // Write and commit request together: the write is part of the commit.
    wr_valid = 1'b1; wr_band = 2'd2; wr_idx = 5'd0; wr_data = 16'h9240;
    commit_req = 1'b1; commit_band = 2'd2;
    model_write(2, 0, 16'h9240);
    pending_band = 2;
    idle(1);
    wr_valid = 1'b0; commit_req = 1'b0;
    idle(2);
    do_tick();
    drain();
    chk("simul_band2_tap0", 32'(coef_active[(2*ORDER)*CW +: CW]), 32'h9240);

    // Random traffic.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        do_commit(int'($urandom_range(0, 3)), int'($urandom_range(0, 5)));
      end else begin
        logic [CW-1:0] d;
        d = CW'($urandom);
        if ($urandom_range(0, 7) == 0) d = {d[CW-1], {(CW-1){1'b0}}};
        do_write(int'($urandom_range(0, 3)), int'($urandom_range(0, 31)), d);
      end
      if (n % 10 == 9) chk_vec("idle_active", coef_active, flat_active());
    end
    chk("rand_err_idx", 32'(err_idx), 32'(err_m));

    // Reset during WAIT_TICK aborts the commit.
    do_write(3, 5, 16'h0abc);
    do_req(3);
    idle(2);
    rst = 1'b0;
    model_reset();
    idle(3);
    rst = 1'b1;
    idle(1);
    chk_vec("abort_active", coef_active, '0);
    chk("abort_band_valid", 32'(band_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_wr_ready", 32'(wr_ready), 32'd1);
    chk("abort_err_idx", 32'(err_idx), 32'd0);
    do_tick();
    idle(4);
    chk_vec("abort_after_tick", coef_active, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
